// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the dynamic branch predictor and its pipeline neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_predictor_pkg;

    // 2-bit saturating counter state; bit[1] is the prediction bit used everywhere
    typedef logic [1:0] bp_state_t;

    localparam bp_state_t SNT = 2'b00;  // strongly not-taken
    localparam bp_state_t WNT = 2'b01;  // weakly not-taken
    localparam bp_state_t WT  = 2'b10;  // weakly taken
    localparam bp_state_t ST  = 2'b11;  // strongly taken

    localparam int DEFAULT_INDEX_BITS = 4;

    // Prediction bit of a counter state
    function automatic logic bp_taken(input bp_state_t s);
        return s[1];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating increment/decrement next-state function.
// Latency: combinational.
// Backpressure: none.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  bp_state_t state_i,
    input  logic      taken_i,
    output bp_state_t next_o
);

    // Move one step toward the resolved outcome, holding at either end
    always_comb begin
        next_o = state_i;
        if (taken_i) begin
            if (state_i != ST) begin
                next_o = state_i + 2'd1;
            end
        end else begin
            if (state_i != SNT) begin
                next_o = state_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ID-stage branch predictor: 2-bit counter table indexed by PC, trained from EX, plus stats counters.
// Latency: lookup and target are combinational; training visible the cycle after the EX branch.
// Backpressure: none; every cycle with IDEX_Branch_i set is exactly one update.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int        INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter bp_state_t INIT_STATE = ST,
    parameter int        CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IFID_Branch_i,
    input  logic [31:0]      IFID_PC_i,
    input  logic [31:0]      IFID_immediate_i,
    input  logic             IDEX_Branch_i,
    input  logic [31:0]      IDEX_PC_i,
    input  logic             IDEX_prediction_i,
    input  logic             Zero_i,
    output logic             predict_o,
    output logic [31:0]      pred_target_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    bp_state_t               tbl_q [ENTRIES];
    bp_state_t               tbl_d [ENTRIES];
    logic [CNT_W-1:0]        branch_cnt_q,     branch_cnt_d;
    logic [CNT_W-1:0]        mispredict_cnt_q, mispredict_cnt_d;

    logic [INDEX_BITS-1:0]   ridx;
    logic [INDEX_BITS-1:0]   widx;
    bp_state_t               upd_state;
    logic                    mispredict;

    // Word-aligned PCs: low two bits and everything above the index alias freely
    assign ridx = IFID_PC_i[INDEX_BITS+1:2];
    assign widx = IDEX_PC_i[INDEX_BITS+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{IFID_PC_i[31:INDEX_BITS+2], IFID_PC_i[1:0],
                                IDEX_PC_i[31:INDEX_BITS+2], IDEX_PC_i[1:0],
                                IFID_immediate_i[31]};

    // Lookup reads the registered table, so a same-cycle write to this index is not bypassed
    assign predict_o     = IFID_Branch_i & bp_taken(tbl_q[ridx]);
    assign pred_target_o = IFID_PC_i + {IFID_immediate_i[30:0], 1'b0};

    sat_counter2 u_sat_counter2 (
        .state_i (tbl_q[widx]),
        .taken_i (Zero_i),
        .next_o  (upd_state)
    );

    assign mispredict = IDEX_Branch_i & (IDEX_prediction_i != Zero_i);

    // Next table contents: only the resolved branch's entry moves
    always_comb begin
        tbl_d = tbl_q;
        if (IDEX_Branch_i) begin
            tbl_d[widx] = upd_state;
        end
    end

    // Statistics advance once per resolved branch and wrap naturally
    always_comb begin
        branch_cnt_d     = branch_cnt_q     + {{(CNT_W-1){1'b0}}, IDEX_Branch_i};
        mispredict_cnt_d = mispredict_cnt_q + {{(CNT_W-1){1'b0}}, mispredict};
    end

    // Counter table register; reset loads every entry with the initial bias
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= INIT_STATE;
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // Statistics registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (32-bit stats instance plus a 4-bit stats instance).
// Inputs are driven just after the falling edge and outputs sampled 1ns later.
// Updates therefore land on the rising edge between consecutive vectors.
module tb_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        IFID_Branch_i;
    logic [31:0] IFID_PC_i;
    logic [31:0] IFID_immediate_i;
    logic        IDEX_Branch_i;
    logic [31:0] IDEX_PC_i;
    logic        IDEX_prediction_i;
    logic        Zero_i;
    logic        predict_o;
    logic [31:0] pred_target_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispredict_cnt_o;
    logic        predict4_o;
    logic [31:0] pred_target4_o;
    logic [3:0]  branch_cnt4_o;
    logic [3:0]  mispredict_cnt4_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    branch_predictor #(.INDEX_BITS(4), .INIT_STATE(2'b11), .CNT_W(32)) u_dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .IFID_Branch_i     (IFID_Branch_i),
        .IFID_PC_i         (IFID_PC_i),
        .IFID_immediate_i  (IFID_immediate_i),
        .IDEX_Branch_i     (IDEX_Branch_i),
        .IDEX_PC_i         (IDEX_PC_i),
        .IDEX_prediction_i (IDEX_prediction_i),
        .Zero_i            (Zero_i),
        .predict_o         (predict_o),
        .pred_target_o     (pred_target_o),
        .branch_cnt_o      (branch_cnt_o),
        .mispredict_cnt_o  (mispredict_cnt_o)
    );

    branch_predictor #(.INDEX_BITS(4), .INIT_STATE(2'b11), .CNT_W(4)) u_dut4 (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .IFID_Branch_i     (IFID_Branch_i),
        .IFID_PC_i         (IFID_PC_i),
        .IFID_immediate_i  (IFID_immediate_i),
        .IDEX_Branch_i     (IDEX_Branch_i),
        .IDEX_PC_i         (IDEX_PC_i),
        .IDEX_prediction_i (IDEX_prediction_i),
        .Zero_i            (Zero_i),
        .predict_o         (predict4_o),
        .pred_target_o     (pred_target4_o),
        .branch_cnt_o      (branch_cnt4_o),
        .mispredict_cnt_o  (mispredict_cnt4_o)
    );

    typedef struct {
        logic        if_br;
        logic [31:0] if_pc;
        logic [31:0] if_imm;
        logic        ex_br;
        logic [31:0] ex_pc;
        logic        ex_pred;
        logic        zero;
        logic        exp_pred;
        logic [31:0] exp_tgt;
        logic [31:0] exp_bcnt;
        logic [31:0] exp_mcnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic if_br, input logic [31:0] if_pc, input logic [31:0] if_imm,
                       input logic ex_br, input logic [31:0] ex_pc, input logic ex_pred,
                       input logic zero, input logic exp_pred, input logic [31:0] exp_tgt,
                       input logic [31:0] exp_bcnt, input logic [31:0] exp_mcnt);
        vec_t v;
        v.if_br = if_br;   v.if_pc = if_pc;     v.if_imm = if_imm;
        v.ex_br = ex_br;   v.ex_pc = ex_pc;     v.ex_pred = ex_pred;  v.zero = zero;
        v.exp_pred = exp_pred; v.exp_tgt = exp_tgt;
        v.exp_bcnt = exp_bcnt; v.exp_mcnt = exp_mcnt;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic if_br, input logic [31:0] if_pc, input logic [31:0] if_imm,
                         input logic ex_br, input logic [31:0] ex_pc, input logic ex_pred,
                         input logic zero);
        IFID_Branch_i     = if_br;
        IFID_PC_i         = if_pc;
        IFID_immediate_i  = if_imm;
        IDEX_Branch_i     = ex_br;
        IDEX_PC_i         = ex_pc;
        IDEX_prediction_i = ex_pred;
        Zero_i            = zero;
    endtask

    initial begin
        logic [4:0] pat;
        rst_i = 1'b1;
        drive(1'b1, 32'h80, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        //   if_br if_pc          if_imm        ex_br ex_pc   pred zero  exp_pred exp_tgt    bcnt mcnt
        // Training of PC 0x40 (index 0): 11->10->01->00, hold 00, then 01, 10
        add(1, 32'h40,       32'h0,        0, 32'h0,  0, 0,   1, 32'h40,       0, 0);
        add(1, 32'h40,       32'h0,        1, 32'h40, 1, 0,   1, 32'h40,       0, 0);
        add(1, 32'h40,       32'h0,        1, 32'h40, 1, 0,   1, 32'h40,       1, 1);
        add(1, 32'h40,       32'h0,        1, 32'h40, 0, 0,   0, 32'h40,       2, 2);
        add(1, 32'h40,       32'h0,        0, 32'h0,  0, 0,   0, 32'h40,       3, 2);
        add(1, 32'h40,       32'h0,        1, 32'h40, 0, 0,   0, 32'h40,       3, 2);
        add(1, 32'h40,       32'h0,        1, 32'h40, 0, 1,   0, 32'h40,       4, 2);
        add(1, 32'h40,       32'h0,        0, 32'h0,  0, 0,   0, 32'h40,       5, 3);
        add(1, 32'h40,       32'h0,        1, 32'h40, 0, 1,   0, 32'h40,       5, 3);
        add(1, 32'h40,       32'h0,        0, 32'h0,  0, 0,   1, 32'h40,       6, 4);
        // Same-cycle read/write of index 0 moving 10->01: old value now, new value next
        add(1, 32'h40,       32'h0,        1, 32'h40, 1, 0,   1, 32'h40,       6, 4);
        add(1, 32'h40,       32'h0,        0, 32'h0,  0, 0,   0, 32'h40,       7, 5);
        // Train PC 0x44 (index 1) down to 00 while ID holds a non-branch
        add(0, 32'h44,       32'h0,        1, 32'h44, 0, 0,   0, 32'h44,       7, 5);
        add(0, 32'h44,       32'h0,        1, 32'h44, 0, 0,   0, 32'h44,       8, 5);
        add(0, 32'h44,       32'h0,        1, 32'h44, 0, 0,   0, 32'h44,       9, 5);
        // Aliasing: 0x84 shares index 1, 0x48 is untouched index 2
        add(1, 32'h84,       32'h0,        0, 32'h0,  0, 0,   0, 32'h84,      10, 5);
        add(1, 32'h48,       32'h0,        0, 32'h0,  0, 0,   1, 32'h48,      10, 5);
        add(1, 32'h44,       32'h0,        0, 32'h0,  0, 0,   0, 32'h44,      10, 5);
        // Non-branch in EX with prediction != outcome changes nothing
        add(1, 32'h48,       32'h0,        0, 32'h48, 1, 0,   1, 32'h48,      10, 5);
        add(1, 32'h48,       32'h0,        0, 32'h0,  0, 0,   1, 32'h48,      10, 5);
        // Target arithmetic, including negative offset and 32-bit wrap
        add(1, 32'h100,      32'hFFFFFFF8, 0, 32'h0,  0, 0,   0, 32'hF0,      10, 5);
        add(1, 32'h100,      32'h10,       0, 32'h0,  0, 0,   0, 32'h120,     10, 5);
        add(1, 32'hFFFFFFFC, 32'h4,        0, 32'h0,  0, 0,   1, 32'h4,       10, 5);

        // Reset state, checked while reset is still asserted
        @(negedge clk_i);
        #1;
        check("reset_predict", {31'd0, predict_o}, 32'd1);
        check("reset_bcnt", branch_cnt_o, 32'd0);
        check("reset_mcnt", mispredict_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk_i);
            drive(vq[i].if_br, vq[i].if_pc, vq[i].if_imm, vq[i].ex_br, vq[i].ex_pc,
                  vq[i].ex_pred, vq[i].zero);
            #1;
            check($sformatf("v%0d_predict", i), {31'd0, predict_o}, {31'd0, vq[i].exp_pred});
            check($sformatf("v%0d_target", i), pred_target_o, vq[i].exp_tgt);
            check($sformatf("v%0d_bcnt", i), branch_cnt_o, vq[i].exp_bcnt);
            check($sformatf("v%0d_mcnt", i), mispredict_cnt_o, vq[i].exp_mcnt);
            check($sformatf("v%0d_bcnt4", i), {28'd0, branch_cnt4_o}, vq[i].exp_bcnt & 32'hF);
        end

        // Asynchronous reset between edges while a training update is pending
        @(negedge clk_i);
        drive(1'b1, 32'h40, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_predict", {31'd0, predict_o}, 32'd1);
        check("async_rst_bcnt", branch_cnt_o, 32'd0);
        check("async_rst_mcnt", mispredict_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(1'b1, 32'h44, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("post_rst_predict_44", {31'd0, predict_o}, 32'd1);
        check("post_rst_bcnt", branch_cnt_o, 32'd0);

        // 16 mispredicted branches: 32-bit counts reach 16, 4-bit counts wrap to 0
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h4C, 1'b1, 1'b0);
            #1;
            check($sformatf("wrap_bcnt4_%0d", i), {28'd0, branch_cnt4_o}, i);
        end
        @(negedge clk_i);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("wrap_bcnt", branch_cnt_o, 32'd16);
        check("wrap_mcnt", mispredict_cnt_o, 32'd16);
        check("wrap_bcnt4", {28'd0, branch_cnt4_o}, 32'd0);
        check("wrap_mcnt4", {28'd0, mispredict_cnt4_o}, 32'd0);

        // Five branches, two of them mispredicted
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        pat = 5'b01001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h50, pat[i], 1'b0);
        end
        @(negedge clk_i);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h50, 1'b1, 1'b0);
        #1;
        check("stats5_bcnt", branch_cnt_o, 32'd5);
        check("stats5_mcnt", mispredict_cnt_o, 32'd2);
        @(negedge clk_i);
        #1;
        check("stats5_hold_bcnt", branch_cnt_o, 32'd5);
        check("stats5_hold_mcnt", mispredict_cnt_o, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
